// File: rtl/program_loader.sv
// Boot-time instruction store and loader: fills an 8x8 memory from a valid/ready byte stream,
// then releases the CPU from reset. Optional checksum verification is enabled by `define CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W      = 3,
    parameter int DEPTH       = 8,
    parameter int INSTR_W     = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               reload,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               cpu_reset,
    output logic               loaded,
    output logic [ADDR_W:0]    load_count,
    output logic               err
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_HOLD,
`ifdef CHECKSUM_EN
        S_CHECK,
        S_ERROR,
`endif
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [INSTR_W-1:0]  mem_q [DEPTH];
    logic [INSTR_W-1:0]  mem_d [DEPTH];
`ifdef CHECKSUM_EN
    logic [INSTR_W-1:0]  csum_q, csum_d;
`endif

    logic                xfer;
    logic [ADDR_W-1:0]   wr_ptr;

    // The write pointer is the low bits of the word count; the count never passes DEPTH.
    assign wr_ptr = count_q[ADDR_W-1:0];
    assign xfer   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        mem_d   = mem_q;
`ifdef CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (reload) begin
            state_d = S_LOAD;
            count_d = '0;
            hold_d  = '0;
`ifdef CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (xfer) begin
`ifdef CHECKSUM_EN
                        // A beat flagged last carries the checksum instead of an instruction.
                        if (in_last) begin
                            state_d = (in_data == csum_q) ? S_HOLD : S_ERROR;
                            hold_d  = '0;
                        end else begin
                            mem_d[wr_ptr] = in_data;
                            csum_d        = csum_q ^ in_data;
                            count_d       = count_q + (ADDR_W + 1)'(1);
                            if (count_q == LAST_COUNT) begin
                                state_d = S_CHECK;
                            end
                        end
`else
                        mem_d[wr_ptr] = in_data;
                        count_d       = count_q + (ADDR_W + 1)'(1);
                        if (in_last || count_q == LAST_COUNT) begin
                            state_d = S_HOLD;
                            hold_d  = '0;
                        end
`endif
                    end
                end
`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        state_d = (in_data == csum_q) ? S_HOLD : S_ERROR;
                        hold_d  = '0;
                    end
                end
`endif
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
            count_q <= '0;
            hold_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            mem_q   <= mem_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

`ifdef CHECKSUM_EN
    assign in_ready = (state_q == S_LOAD || state_q == S_CHECK) && !reload;
    assign err      = (state_q == S_ERROR);
`else
    assign in_ready = (state_q == S_LOAD) && !reload;
    assign err      = 1'b0;
`endif

    assign fetch_instr = mem_q[fetch_addr];
    assign cpu_reset   = (state_q != S_RUN);
    assign loaded      = (state_q == S_HOLD) || (state_q == S_RUN);
    assign load_count  = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: a vector table for the main load/run/reload
// flow plus hand-written sequences for partial loads, gaps, async reset and the checksum build.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       reload;
    logic [2:0] fetch_addr;
    logic [7:0] fetch_instr;
    logic       cpu_reset;
    logic       loaded;
    logic [3:0] load_count;
    logic       err;

    int checks   = 0;
    int failures = 0;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .reload     (reload),
        .fetch_addr (fetch_addr),
        .fetch_instr(fetch_instr),
        .cpu_reset  (cpu_reset),
        .loaded     (loaded),
        .load_count (load_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       rld;
        logic [2:0] addr;
        logic       e_ready;
        logic [3:0] e_count;
        logic       e_loaded;
        logic       e_cpu_reset;
        logic [7:0] e_instr;
    } vector_t;

    vector_t vecs [17];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        #2;
        reset    = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
    endtask

    task automatic check_fetch(input string name, input logic [2:0] a, input logic [7:0] exp);
        fetch_addr = a;
        #1;
        check_byte(name, fetch_instr, exp);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        reload     = 1'b0;
        fetch_addr = 3'd0;
        #12;
        reset = 1'b0;

`ifndef CHECKSUM_EN
        // Inputs sampled at each vector's edge; expectations are the outputs just before it.
        //            valid data  last rld addr rdy cnt  ld  crst instr
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 3'd0, 1'b1, 4'd1, 1'b0, 1'b1, 8'h01};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3'd1, 1'b1, 4'd2, 1'b0, 1'b1, 8'h02};
        vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd2, 1'b1, 4'd3, 1'b0, 1'b1, 8'h03};
        vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 3'd3, 1'b1, 4'd4, 1'b0, 1'b1, 8'h04};
        vecs[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 3'd4, 1'b1, 4'd5, 1'b0, 1'b1, 8'h05};
        vecs[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 3'd5, 1'b1, 4'd6, 1'b0, 1'b1, 8'h06};
        vecs[7]  = '{1'b1, 8'h08, 1'b0, 1'b0, 3'd6, 1'b1, 4'd7, 1'b0, 1'b1, 8'h07};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 4'd8, 1'b1, 1'b1, 8'h08};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 4'd8, 1'b1, 1'b1, 8'h04};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 4'd8, 1'b1, 1'b0, 8'h04};
        vecs[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 3'd0, 1'b0, 4'd8, 1'b1, 1'b0, 8'h01};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 4'd8, 1'b1, 1'b0, 8'h01};
        vecs[13] = '{1'b1, 8'h77, 1'b0, 1'b1, 3'd0, 1'b0, 4'd8, 1'b1, 1'b0, 8'h01};
        vecs[14] = '{1'b1, 8'h77, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b1, 8'h01};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 4'd1, 1'b0, 1'b1, 8'h02};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 4'd1, 1'b0, 1'b1, 8'h77};

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid   = vecs[i].valid;
            in_data    = vecs[i].data;
            in_last    = vecs[i].last;
            reload     = vecs[i].rld;
            fetch_addr = vecs[i].addr;
            #1;
            check_bit ($sformatf("v%0d in_ready", i),    in_ready,  vecs[i].e_ready);
            check_byte($sformatf("v%0d load_count", i),  {4'b0, load_count}, {4'b0, vecs[i].e_count});
            check_bit ($sformatf("v%0d loaded", i),      loaded,    vecs[i].e_loaded);
            check_bit ($sformatf("v%0d cpu_reset", i),   cpu_reset, vecs[i].e_cpu_reset);
            check_byte($sformatf("v%0d fetch_instr", i), fetch_instr, vecs[i].e_instr);
            check_bit ($sformatf("v%0d err", i),         err,       1'b0);
        end
        reload = 1'b0;

        // Partial load: in_last on the third beat ends the load early.
        do_reset();
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b1);
        idle();
        check_byte("partial count", {4'b0, load_count}, 8'd3);
        check_bit ("partial loaded", loaded, 1'b1);
        check_bit ("partial ready", in_ready, 1'b0);
        check_bit ("partial hold cpu_reset", cpu_reset, 1'b1);
        check_fetch("partial mem2", 3'd2, 8'hA3);
        check_fetch("partial mem5", 3'd5, 8'h00);
        @(negedge clk);
        #1;
        check_bit("partial hold2 cpu_reset", cpu_reset, 1'b1);
        @(negedge clk);
        #1;
        check_bit("partial run cpu_reset", cpu_reset, 1'b0);

        // Gaps in in_valid: only the valid cycles write.
        do_reset();
        beat(8'h10, 1'b0);
        idle();
        @(posedge clk);
        beat(8'h20, 1'b0);
        idle();
        @(posedge clk);
        beat(8'h30, 1'b1);
        idle();
        check_byte("gaps count", {4'b0, load_count}, 8'd3);
        check_fetch("gaps mem0", 3'd0, 8'h10);
        check_fetch("gaps mem1", 3'd1, 8'h20);
        check_fetch("gaps mem2", 3'd2, 8'h30);
        check_fetch("gaps mem3", 3'd3, 8'h00);

        // Asynchronous reset in the middle of a load.
        do_reset();
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        idle();
        check_byte("mid count before", {4'b0, load_count}, 8'd4);
        #1;
        reset = 1'b1;
        #1;
        check_bit ("midrst cpu_reset", cpu_reset, 1'b1);
        check_byte("midrst count", {4'b0, load_count}, 8'd0);
        check_bit ("midrst ready", in_ready, 1'b1);
        check_bit ("midrst loaded", loaded, 1'b0);
        for (int a = 0; a < 8; a++) begin
            check_fetch($sformatf("midrst mem%0d", a), 3'(a), 8'h00);
        end
        reset = 1'b0;
`else
        // Good checksum: 0x12 ^ 0x34 = 0x26.
        do_reset();
        beat(8'h12, 1'b0);
        beat(8'h34, 1'b0);
        beat(8'h26, 1'b1);
        idle();
        check_byte("csum count", {4'b0, load_count}, 8'd2);
        check_bit ("csum loaded", loaded, 1'b1);
        check_bit ("csum err", err, 1'b0);
        check_fetch("csum mem2 not stored", 3'd2, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_bit("csum run cpu_reset", cpu_reset, 1'b0);

        // Bad checksum stays in error until reload.
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        beat(8'h12, 1'b0);
        beat(8'h34, 1'b0);
        beat(8'h00, 1'b1);
        idle();
        check_bit("bad err", err, 1'b1);
        check_bit("bad cpu_reset", cpu_reset, 1'b1);
        check_bit("bad ready", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
        end
        #1;
        check_bit("bad err held", err, 1'b1);
        check_bit("bad cpu_reset held", cpu_reset, 1'b1);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        #1;
        check_bit("reload clears err", err, 1'b0);
        check_bit("reload ready", in_ready, 1'b1);
        check_byte("reload count", {4'b0, load_count}, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
